button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
Dual-channel push-button conditioner that sits directly upstream of the control unit. It synchronises the raw left (step) and right (load-from-switch) buttons, filters contact bounce, and emits one-clock pulses on leftBtnDebounce / rightBtnDebounce. These pulses drive PC/IR advance and manual instruction load. Each press yields exactly one pulse, regardless of hold time.

Parameters:
STABLE_CYCLES, 500000, consecutive identical synchronised samples required to accept a press or release (5 ms at 100 MHz); legal range >= 2
CNT_WIDTH, 19, counter width; must satisfy 2**CNT_WIDTH > STABLE_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
leftBtn  input  1  raw, asynchronous, bouncing left button
rightBtn  input  1  raw, asynchronous, bouncing right button
leftBtnDebounce  output  1  one-cycle pulse per accepted left press
rightBtnDebounce  output  1  one-cycle pulse per accepted right press
leftBtnLevel  output  1  debounced level of left button
rightBtnLevel  output  1  debounced level of right button

Behaviour:
- Reset: async on reset==0, independent of clk. Synchroniser flops=0, state=IDLE, counters=0, all four outputs=0. Reset mid-count discards progress, so no pulse follows. Release of reset needs no pulse; a button held through reset is treated as a new press after release.
- Channels are identical and fully independent. Both may pulse in the same cycle; no priority or arbitration.
- Per channel: 2-flop synchroniser, raw -> s1 -> s2. The FSM uses s2 only.
- FSM, registered. cnt is CNT_WIDTH bits.
  - IDLE: s2=1 -> PRESS_WAIT, cnt<=1. Otherwise stay.
  - PRESS_WAIT: s2=0 -> IDLE, cnt<=0. s2=1 and cnt==STABLE_CYCLES-1 -> HELD, pulse<=1, level<=1, cnt<=0. Otherwise cnt<=cnt+1.
  - HELD: s2=0 -> RELEASE_WAIT, cnt<=1. Otherwise stay (long hold, no further pulses).
  - RELEASE_WAIT: s2=1 -> HELD, cnt<=0, no pulse. s2=0 and cnt==STABLE_CYCLES-1 -> IDLE, level<=0, cnt<=0. Otherwise cnt<=cnt+1.
- Pulse register: 1 only in the cycle after the PRESS_WAIT->HELD transition, otherwise 0. Never high for two consecutive cycles.
- Latency, clean input: raw rises and is first sampled at edge 0. Pulse and level go high after edge STABLE_CYCLES+1. Pulse falls after edge STABLE_CYCLES+2.
- Release latency: level falls after edge STABLE_CYCLES+1 counted from the first edge sampling raw low.
- Counter never wraps: it is cleared on every exit and bounded by STABLE_CYCLES-1.
- Outputs are registered; no combinational path from leftBtn or rightBtn to any output.

Test Plan (STABLE_CYCLES=4):
- Reset: hold reset=0 with both buttons=1, then release -> all outputs 0 during reset. leftBtnDebounce pulses once at edge 5 after release; leftBtnLevel=1.
- Clean press: leftBtn 0->1 at edge 0, held 20 cycles -> leftBtnDebounce=1 for exactly one cycle after edge 5, leftBtnLevel=1 from edge 5, rightBtnDebounce=0 throughout.
- Bounce on press: leftBtn toggles 1,0,1,1,0 (one cycle each), then steady 1 -> no pulse during the bounce. Exactly one pulse, 5 edges after the last 0->1.
- Bounce on release and long hold: hold rightBtn 1000 cycles, then release with 1-cycle glitches 0,1,0 -> exactly one rightBtnDebounce pulse total. rightBtnLevel stays 1 through the glitches and falls 5 edges after steady 0.
- Simultaneous: leftBtn and rightBtn rise on the same edge -> both pulses are high in the same cycle, each for one cycle.
- Reset mid-operation: assert reset at edge 3 of a press (in PRESS_WAIT) -> outputs 0 immediately. After reset release with the button still held, a pulse occurs 5 edges later. No double pulse.

Source files
------------

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - dual-channel push-button synchroniser, debouncer and one-shot press pulse
// Each channel accepts a press or release only after STABLE_CYCLES identical synchronised samples.

module button_debounce_channel #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o,
  output logic level_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q;
  logic [1:0]           sync_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 pulse_q;
  logic                 level_q;
  logic                 btn_s2;

  assign btn_s2 = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s2) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s2) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s2) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to HELD silently: the press was already reported.
          if (btn_s2) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;

endmodule

module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic leftBtn,
  input  logic rightBtn,
  output logic leftBtnDebounce,
  output logic rightBtnDebounce,
  output logic leftBtnLevel,
  output logic rightBtnLevel
);

  button_debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_left (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (leftBtn),
    .pulse_o(leftBtnDebounce),
    .level_o(leftBtnLevel)
  );

  button_debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_right (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (rightBtn),
    .pulse_o(rightBtnDebounce),
    .level_o(rightBtnLevel)
  );

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer with STABLE_CYCLES=4
// Stimulus pushes expected pulse/level events (edge index, value); a negedge monitor pops and compares.

module tb_button_debouncer;

  localparam int S   = 4;
  localparam int LAT = S + 1;

  typedef struct {
    int cyc;
    bit val;
  } lvl_ev_t;

  logic clk = 1'b0;
  logic reset;
  logic leftBtn;
  logic rightBtn;
  logic leftBtnDebounce;
  logic rightBtnDebounce;
  logic leftBtnLevel;
  logic rightBtnLevel;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int      exp_lp[$];
  int      exp_rp[$];
  lvl_ev_t exp_ll[$];
  lvl_ev_t exp_rl[$];

  logic prev_ll = 1'b0;
  logic prev_rl = 1'b0;

  button_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_WIDTH    (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .leftBtn         (leftBtn),
    .rightBtn        (rightBtn),
    .leftBtnDebounce (leftBtnDebounce),
    .rightBtnDebounce(rightBtnDebounce),
    .leftBtnLevel    (leftBtnLevel),
    .rightBtnLevel   (rightBtnLevel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event at cycle %0d, expected none", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic lvl_ev_t mk(input int c, input bit v);
    lvl_ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (leftBtnDebounce) begin
        if (exp_lp.size() == 0) unexpected("left_pulse");
        else cmp("left_pulse_cycle", cyc, exp_lp.pop_front());
      end
      if (rightBtnDebounce) begin
        if (exp_rp.size() == 0) unexpected("right_pulse");
        else cmp("right_pulse_cycle", cyc, exp_rp.pop_front());
      end
      if (leftBtnLevel != prev_ll) begin
        if (exp_ll.size() == 0) unexpected("left_level");
        else begin
          lvl_ev_t e;
          e = exp_ll.pop_front();
          cmp("left_level_cycle", cyc, e.cyc);
          cmp("left_level_value", int'(leftBtnLevel), int'(e.val));
        end
      end
      if (rightBtnLevel != prev_rl) begin
        if (exp_rl.size() == 0) unexpected("right_level");
        else begin
          lvl_ev_t e;
          e = exp_rl.pop_front();
          cmp("right_level_cycle", cyc, e.cyc);
          cmp("right_level_value", int'(rightBtnLevel), int'(e.val));
        end
      end
    end
    prev_ll <= leftBtnLevel;
    prev_rl <= rightBtnLevel;
  end

  task automatic check_all_zero(input string tag);
    cmp({tag, "_left_pulse"}, int'(leftBtnDebounce), 0);
    cmp({tag, "_right_pulse"}, int'(rightBtnDebounce), 0);
    cmp({tag, "_left_level"}, int'(leftBtnLevel), 0);
    cmp({tag, "_right_level"}, int'(rightBtnLevel), 0);
  endtask

  initial begin
    int e;
    int seq[5];
    int waited;
    seq = '{1, 0, 1, 1, 0};

    // Reset held with both buttons down, then released: both treated as new presses.
    reset = 1'b0; leftBtn = 1'b1; rightBtn = 1'b1;
    tick(3);
    check_all_zero("in_reset");
    e = cyc + 1;
    reset = 1'b1;
    exp_lp.push_back(e + LAT); exp_rp.push_back(e + LAT);
    exp_ll.push_back(mk(e + LAT, 1)); exp_rl.push_back(mk(e + LAT, 1));
    tick(10);
    e = cyc + 1;
    leftBtn = 1'b0; rightBtn = 1'b0;
    exp_ll.push_back(mk(e + LAT, 0)); exp_rl.push_back(mk(e + LAT, 0));
    tick(10);

    // Clean left press, held 20 cycles.
    e = cyc + 1;
    leftBtn = 1'b1;
    exp_lp.push_back(e + LAT); exp_ll.push_back(mk(e + LAT, 1));
    tick(20);
    e = cyc + 1;
    leftBtn = 1'b0;
    exp_ll.push_back(mk(e + LAT, 0));
    tick(10);

    // Bounce on press: 1,0,1,1,0 then steady 1.
    foreach (seq[i]) begin
      leftBtn = seq[i][0];
      tick(1);
    end
    e = cyc + 1;
    leftBtn = 1'b1;
    exp_lp.push_back(e + LAT); exp_ll.push_back(mk(e + LAT, 1));
    tick(15);
    e = cyc + 1;
    leftBtn = 1'b0;
    exp_ll.push_back(mk(e + LAT, 0));
    tick(10);

    // Long right hold, then release with 0,1,0 glitch before steady 0.
    e = cyc + 1;
    rightBtn = 1'b1;
    exp_rp.push_back(e + LAT); exp_rl.push_back(mk(e + LAT, 1));
    tick(1000);
    rightBtn = 1'b0; tick(1);
    rightBtn = 1'b1; tick(1);
    e = cyc + 1;
    rightBtn = 1'b0;
    exp_rl.push_back(mk(e + LAT, 0));
    tick(12);

    // Simultaneous press on both channels.
    e = cyc + 1;
    leftBtn = 1'b1; rightBtn = 1'b1;
    exp_lp.push_back(e + LAT); exp_rp.push_back(e + LAT);
    exp_ll.push_back(mk(e + LAT, 1)); exp_rl.push_back(mk(e + LAT, 1));
    tick(12);
    e = cyc + 1;
    leftBtn = 1'b0; rightBtn = 1'b0;
    exp_ll.push_back(mk(e + LAT, 0)); exp_rl.push_back(mk(e + LAT, 0));
    tick(10);

    // Reset during PRESS_WAIT discards progress; held button re-qualifies after release.
    e = cyc + 1;
    leftBtn = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick(2);
    check_all_zero("mid_reset_hold");
    e = cyc + 1;
    reset = 1'b1;
    exp_lp.push_back(e + LAT); exp_ll.push_back(mk(e + LAT, 1));
    tick(15);
    e = cyc + 1;
    leftBtn = 1'b0;
    exp_ll.push_back(mk(e + LAT, 0));

    waited = 0;
    while ((exp_lp.size() + exp_rp.size() + exp_ll.size() + exp_rl.size()) != 0 && waited < 50) begin
      tick(1);
      waited++;
    end
    tick(5);
    cmp("left_pulse_left_over", exp_lp.size(), 0);
    cmp("right_pulse_left_over", exp_rp.size(), 0);
    cmp("left_level_left_over", exp_ll.size(), 0);
    cmp("right_level_left_over", exp_rl.size(), 0);
    check_all_zero("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
